lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter MEM_BYTES, default 512: byte size of the attached data memory; any access touching byte >= MEM_BYTES faults.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  pipeline presents a load/store request.
REQ-005 req_ready  output  1  block accepts a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_wbits  input  2  store width: 00 word, 01 half, 10 byte; 11 is illegal.
REQ-008 req_rbits  input  3  load type: 000 lw, 001 lhu, 010 lh, 011 lbu, 100 lb; 101-111 are illegal.
REQ-009 req_addr  input  32  byte address; req_wdata  input  32  store data.
REQ-010 resp_valid  output  1  response available; resp_ready  input  1  pipeline consumes the response.
REQ-011 resp_rdata  output  32  load result, already extended by memory; 0 for stores and faults.
REQ-012 resp_err  output  1  access faulted (misaligned, out of range or illegal code).
REQ-013 MemR, MemWr  output  1 each  memory strobes; MemWrBits  output  2; MemRBits  output  3; mem_addr, mem_wdata  output  32; ReadData  input  32.
REQ-014 n_loads, n_stores, n_faults  output  16 each  saturating event counters.

Function
REQ-015 FSM states: IDLE, ACCESS, RESP.
REQ-016 req_ready = 1 only in IDLE.
REQ-017 IDLE: when req_valid is high, latch we, wbits, rbits, addr and wdata.
REQ-018 IDLE: a legal request moves to ACCESS; a faulting request moves to RESP with the error flag set.
REQ-019 Misalignment: word accesses require addr[1:0] == 0; half accesses require addr[0] == 0; byte accesses are always aligned.
REQ-020 Range: addr + width - 1 >= MEM_BYTES faults; compute in 33 bits so wrap-around near 0xFFFFFFFF faults.
REQ-021 ACCESS lasts exactly one cycle.
REQ-022 In ACCESS, MemR = ~we and MemWr = we.
REQ-023 In ACCESS, MemWrBits, MemRBits, mem_addr and mem_wdata come from the latched values.
REQ-024 Outside ACCESS, MemR, MemWr, MemWrBits, MemRBits, mem_addr and mem_wdata are 0.
REQ-025 ACCESS, load: capture ReadData at the closing edge into the response register.
REQ-026 ACCESS, store: load 0 into the response register.
REQ-027 RESP: resp_valid = 1; resp_rdata and resp_err stay stable until resp_valid && resp_ready.
REQ-028 RESP: on resp_valid && resp_ready, go to IDLE; a new request is accepted no earlier than the following cycle.
REQ-029 Latency: request accepted at edge N; memory strobe during cycle N+1; resp_valid from cycle N+2.
REQ-030 Throughput: at most one request per 3 cycles.
REQ-031 A faulting request never asserts MemR or MemWr; resp_valid rises the cycle after acceptance.
REQ-032 Counters increment on response handshake only: n_faults if err, else n_stores or n_loads.
REQ-033 Counters saturate at 0xFFFF.
REQ-034 resp_ready held high with req_valid held high: the sequence IDLE, ACCESS, RESP, IDLE repeats with no lost or duplicated request.

Reset
REQ-035 While rst is high at an edge: go to IDLE and clear all outputs, latched request fields and counters to 0.
REQ-036 req_ready reads 1 in the first cycle after reset.
REQ-037 Reset during ACCESS or RESP aborts the transaction with no response.
REQ-038 A store whose ACCESS cycle has completed is not undone by a later reset.

Structure
REQ-039 Shared package holds: load codes (LW, LHU, LH, LBU, LB), store codes (SW, SH, SB), the FSM state enum and the width-from-code helper.
REQ-040 A single sub-module, lsu_align_chk (combinational fault detect from code and address), is natural; counters stay inline.

Verification
REQ-041 sw 0x12345678 to 0x10, then lw 0x10 -> MemWr one cycle with addr 0x10; second response rdata 0x12345678, err 0; n_stores 1, n_loads 1.
REQ-042 sb 0x80 to 0x21, then lb 0x21 and lbu 0x21 -> rdata 0xFFFFFF80, then 0x00000080.
REQ-043 lw 0x13; sh 0x1FF; lw 0x1FE -> three responses, each with err 1 and rdata 0; MemR and MemWr never assert; n_faults 3.
REQ-044 resp_ready held low 5 cycles in RESP -> resp_valid, rdata and err stable; req_ready 0 throughout; then resp_ready 1 -> IDLE.
REQ-045 Assert rst during ACCESS of a load -> next cycle: IDLE, resp_valid 0, req_ready 1, counters 0.
REQ-046 lw with addr 0xFFFFFFFC -> err 1 (wrap-around), no strobe.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: access codes, FSM states and access-width helper shared by the LSU
package lsu_ctrl_pkg;
    localparam logic [2:0] LW = 3'b000, LHU = 3'b001, LH = 3'b010, LBU = 3'b011, LB = 3'b100;
    localparam logic [1:0] SW = 2'b00, SH = 2'b01, SB = 2'b10;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    // 0 marks an illegal code
    function automatic logic [2:0] acc_width(input logic we, input logic [1:0] wbits, input logic [2:0] rbits);
        return we ? (wbits == SW ? 3'd4 : wbits == SH ? 3'd2 : wbits == SB ? 3'd1 : 3'd0)
                  : (rbits == LW ? 3'd4 : (rbits == LHU || rbits == LH) ? 3'd2 :
                     (rbits == LBU || rbits == LB) ? 3'd1 : 3'd0);
    endfunction
endpackage

// File: rtl/lsu_ctrl_align_chk.sv
// lsu_align_chk: flags illegal codes, misaligned addresses and out-of-range accesses
module lsu_align_chk
    import lsu_ctrl_pkg::*;
#(
    parameter int MEM_BYTES = 512
) (
    input  logic        we,
    input  logic [1:0]  wbits,
    input  logic [2:0]  rbits,
    input  logic [31:0] addr,
    output logic        fault
);
    logic [2:0]  w;
    logic [32:0] last;
    always_comb begin
        w     = acc_width(we, wbits, rbits);
        last  = {1'b0, addr} + {30'd0, w} - 33'd1;
        fault = (w == 3'd0) || (w == 3'd4 && addr[1:0] != 2'b00) || (w == 3'd2 && addr[0])
                || (last >= 33'(MEM_BYTES));
    end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: three-state load/store unit with fault detection and saturating event counters
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int MEM_BYTES = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_wbits,
    input  logic [2:0]  req_rbits,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemR,
    output logic        MemWr,
    output logic [1:0]  MemWrBits,
    output logic [2:0]  MemRBits,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] ReadData,
    output logic [15:0] n_loads,
    output logic [15:0] n_stores,
    output logic [15:0] n_faults
);
    state_t      state;
    logic        we_q, err_q, fault, acc;
    logic [1:0]  wbits_q;
    logic [2:0]  rbits_q;
    logic [31:0] addr_q, wdata_q, rdata_q;

    lsu_align_chk #(.MEM_BYTES(MEM_BYTES)) u_chk (
        .we(req_we), .wbits(req_wbits), .rbits(req_rbits), .addr(req_addr), .fault(fault)
    );

    assign acc        = state == ACCESS;
    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign MemR       = acc && !we_q;
    assign MemWr      = acc && we_q;
    assign MemWrBits  = acc ? wbits_q : 2'b00;
    assign MemRBits   = acc ? rbits_q : 3'b000;
    assign mem_addr   = acc ? addr_q : 32'd0;
    assign mem_wdata  = acc ? wdata_q : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            wbits_q  <= 2'b00;
            rbits_q  <= 3'b000;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            n_loads  <= 16'd0;
            n_stores <= 16'd0;
            n_faults <= 16'd0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    wbits_q <= req_wbits;
                    rbits_q <= req_rbits;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    err_q   <= fault;
                    rdata_q <= 32'd0;
                    state   <= fault ? RESP : ACCESS;
                end
                ACCESS: begin
                    rdata_q <= we_q ? 32'd0 : ReadData;
                    state   <= RESP;
                end
                default: if (resp_ready) begin
                    state <= IDLE;
                    if (err_q) begin
                        if (n_faults != 16'hFFFF) n_faults <= n_faults + 16'd1;
                    end else if (we_q) begin
                        if (n_stores != 16'hFFFF) n_stores <= n_stores + 16'd1;
                    end else if (n_loads != 16'hFFFF) n_loads <= n_loads + 16'd1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed checks of lsu_ctrl against a little-endian byte memory model
module tb_lsu_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
    logic [1:0]  req_wbits = 2'b00;
    logic [2:0]  req_rbits = 3'b000;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_err, MemR, MemWr;
    logic [1:0]  MemWrBits;
    logic [2:0]  MemRBits;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, ReadData;
    logic [15:0] n_loads, n_stores, n_faults;
    logic [7:0]  mem [0:511];
    int          n_cmp = 0, n_bad = 0;

    lsu_ctrl #(.MEM_BYTES(512)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_wbits(req_wbits), .req_rbits(req_rbits), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .MemR(MemR), .MemWr(MemWr), .MemWrBits(MemWrBits), .MemRBits(MemRBits), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .ReadData(ReadData), .n_loads(n_loads), .n_stores(n_stores),
        .n_faults(n_faults)
    );

    always #5 clk = ~clk;

    // memory performs the extension, as the LSU expects
    always_comb begin
        logic [8:0] a;
        a = mem_addr[8:0];
        ReadData = 32'd0;
        if (MemR)
            case (MemRBits)
                3'b000:  ReadData = {mem[a + 9'd3], mem[a + 9'd2], mem[a + 9'd1], mem[a]};
                3'b001:  ReadData = {16'd0, mem[a + 9'd1], mem[a]};
                3'b010:  ReadData = {{16{mem[a + 9'd1][7]}}, mem[a + 9'd1], mem[a]};
                3'b011:  ReadData = {24'd0, mem[a]};
                3'b100:  ReadData = {{24{mem[a][7]}}, mem[a]};
                default: ReadData = 32'hDEADBEEF;
            endcase
    end

    always @(posedge clk)
        if (MemWr) begin
            mem[mem_addr[8:0]] <= mem_wdata[7:0];
            if (MemWrBits != 2'b10) mem[mem_addr[8:0] + 9'd1] <= mem_wdata[15:8];
            if (MemWrBits == 2'b00) begin
                mem[mem_addr[8:0] + 9'd2] <= mem_wdata[23:16];
                mem[mem_addr[8:0] + 9'd3] <= mem_wdata[31:24];
            end
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic we, input logic [1:0] wb, input logic [2:0] rb,
                           input logic [31:0] a, input logic [31:0] wd);
        req_we = we; req_wbits = wb; req_rbits = rb; req_addr = a; req_wdata = wd;
    endtask

    task automatic xact(input string tag, input logic we, input logic [1:0] wb, input logic [2:0] rb,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
        set_req(we, wb, rb, a, wd);
        req_valid = 1'b1;
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        if (exp_err) begin
            chk({tag, ".fault_resp_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, ".fault_strobe"}, {30'd0, MemR, MemWr}, 32'd0);
        end else begin
            chk({tag, ".strobe"}, {30'd0, MemR, MemWr}, {30'd0, !we, we});
            chk({tag, ".mem_addr"}, mem_addr, a);
            tick();
            chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, ".strobe_off"}, {30'd0, MemR, MemWr}, 32'd0);
        end
        chk({tag, ".rdata"}, resp_rdata, exp_rd);
        chk({tag, ".err"}, 32'(resp_err), 32'(exp_err));
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk({tag, ".idle"}, {30'd0, req_ready, resp_valid}, 32'd2);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'd0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset.ready_valid", {30'd0, req_ready, resp_valid}, 32'd2);
        chk("reset.counters", {n_loads, n_stores}, 32'd0);
        chk("reset.faults", 32'(n_faults), 32'd0);
        chk("reset.strobes", {30'd0, MemR, MemWr}, 32'd0);

        set_req(1'b1, 2'b00, 3'b000, 32'h10, 32'h12345678);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("sw.access_wdata", mem_wdata, 32'h12345678);
        chk("sw.access_ready", 32'(req_ready), 32'd0);
        tick();
        chk("sw.mem_idle", mem_addr | {31'd0, MemWr}, 32'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        xact("lw10", 1'b0, 2'b00, 3'b000, 32'h10, 32'd0, 32'h12345678, 1'b0);
        chk("sw_lw.counts", {n_loads, n_stores}, {16'd1, 16'd1});

        xact("sb21", 1'b1, 2'b10, 3'b000, 32'h21, 32'h80, 32'd0, 1'b0);
        xact("lb21", 1'b0, 2'b00, 3'b100, 32'h21, 32'd0, 32'hFFFFFF80, 1'b0);
        xact("lbu21", 1'b0, 2'b00, 3'b011, 32'h21, 32'd0, 32'h00000080, 1'b0);

        xact("lw13", 1'b0, 2'b00, 3'b000, 32'h13, 32'd0, 32'd0, 1'b1);
        xact("sh1ff", 1'b1, 2'b01, 3'b000, 32'h1FF, 32'hFFFF, 32'd0, 1'b1);
        xact("lw1fe", 1'b0, 2'b00, 3'b000, 32'h1FE, 32'd0, 32'd0, 1'b1);
        chk("fault.count", 32'(n_faults), 32'd3);

        xact("sh1fe", 1'b1, 2'b01, 3'b000, 32'h1FE, 32'h1234BEEF, 32'd0, 1'b0);
        xact("lhu1fe", 1'b0, 2'b00, 3'b001, 32'h1FE, 32'd0, 32'h0000BEEF, 1'b0);
        xact("lh1fe", 1'b0, 2'b00, 3'b010, 32'h1FE, 32'd0, 32'hFFFFBEEF, 1'b0);
        xact("lb1ff", 1'b0, 2'b00, 3'b100, 32'h1FF, 32'd0, 32'hFFFFFFBE, 1'b0);
        xact("lw1fc", 1'b0, 2'b00, 3'b000, 32'h1FC, 32'd0, 32'hBEEF0000, 1'b0);
        xact("lw200", 1'b0, 2'b00, 3'b000, 32'h200, 32'd0, 32'd0, 1'b1);
        xact("rbits101", 1'b0, 2'b00, 3'b101, 32'h20, 32'd0, 32'd0, 1'b1);
        xact("wbits11", 1'b1, 2'b11, 3'b000, 32'h20, 32'hAA, 32'd0, 1'b1);
        xact("lw_wrap", 1'b0, 2'b00, 3'b000, 32'hFFFFFFFC, 32'd0, 32'd0, 1'b1);

        set_req(1'b0, 2'b00, 3'b000, 32'h10, 32'd0);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall.valid_ready", {30'd0, resp_valid, req_ready}, 32'd2);
            chk("stall.rdata", resp_rdata, 32'h12345678);
            chk("stall.err", 32'(resp_err), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("stall.idle", {30'd0, req_ready, resp_valid}, 32'd2);
        chk("totals.loads_stores", {n_loads, n_stores}, {16'd8, 16'd3});
        chk("totals.faults", 32'(n_faults), 32'd7);

        set_req(1'b0, 2'b00, 3'b000, 32'h10, 32'd0);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("abort.in_access", 32'(MemR), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.idle", {30'd0, req_ready, resp_valid}, 32'd2);
        chk("abort.counters", {n_loads, n_stores}, 32'd0);
        chk("abort.faults", 32'(n_faults), 32'd0);

        set_req(1'b0, 2'b00, 3'b000, 32'h10, 32'd0);
        req_valid = 1'b1;
        resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        req_valid = 1'b0;
        resp_ready = 1'b0;
        chk("b2b.loads", 32'(n_loads), 32'd2);
        chk("b2b.idle", {30'd0, req_ready, resp_valid}, 32'd2);
        xact("persist", 1'b0, 2'b00, 3'b000, 32'h10, 32'd0, 32'h12345678, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
